// File: rtl/tone_meter_pkg.sv
// Shared constants for the tone meter and the music player: note frequencies,
// the indexed note table and the widths of the hz/note codes.
package tone_meter_pkg;

  localparam int HZ_W       = 12;
  localparam int NOTE_W     = 5;
  localparam int NOTE_COUNT = 24;

  // Note frequencies in Hz, rounded to the nearest integer
  localparam logic [HZ_W-1:0] NO_VOICE = 12'd0;
  localparam logic [HZ_W-1:0] _4C  = 12'd262;
  localparam logic [HZ_W-1:0] _4CS = 12'd277;
  localparam logic [HZ_W-1:0] _4D  = 12'd294;
  localparam logic [HZ_W-1:0] _4DS = 12'd311;
  localparam logic [HZ_W-1:0] _4E  = 12'd330;
  localparam logic [HZ_W-1:0] _4F  = 12'd349;
  localparam logic [HZ_W-1:0] _4FS = 12'd370;
  localparam logic [HZ_W-1:0] _4G  = 12'd392;
  localparam logic [HZ_W-1:0] _4GS = 12'd415;
  localparam logic [HZ_W-1:0] _4A  = 12'd440;
  localparam logic [HZ_W-1:0] _4AS = 12'd466;
  localparam logic [HZ_W-1:0] _4B  = 12'd494;
  localparam logic [HZ_W-1:0] _5C  = 12'd523;
  localparam logic [HZ_W-1:0] _5CS = 12'd554;
  localparam logic [HZ_W-1:0] _5D  = 12'd587;
  localparam logic [HZ_W-1:0] _5DS = 12'd622;
  localparam logic [HZ_W-1:0] _5E  = 12'd659;
  localparam logic [HZ_W-1:0] _5F  = 12'd698;
  localparam logic [HZ_W-1:0] _5FS = 12'd740;
  localparam logic [HZ_W-1:0] _5G  = 12'd784;
  localparam logic [HZ_W-1:0] _5GS = 12'd831;
  localparam logic [HZ_W-1:0] _5A  = 12'd880;
  localparam logic [HZ_W-1:0] _5AS = 12'd932;
  localparam logic [HZ_W-1:0] _5B  = 12'd988;

  // Note code -> Hz. Index 0 is silence; entries past 24 are padding so that a
  // full 5-bit code indexes the table without a range check.
  localparam logic [HZ_W-1:0] NOTE_HZ [0:31] = '{
    NO_VOICE,
    _4C, _4CS, _4D, _4DS, _4E, _4F, _4FS, _4G, _4GS, _4A, _4AS, _4B,
    _5C, _5CS, _5D, _5DS, _5E, _5F, _5FS, _5G, _5GS, _5A, _5AS, _5B,
    NO_VOICE, NO_VOICE, NO_VOICE, NO_VOICE, NO_VOICE, NO_VOICE, NO_VOICE
  };

  function automatic logic [HZ_W-1:0] abs_diff(input logic [HZ_W-1:0] a,
                                               input logic [HZ_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/note_quantizer.sv
// Maps a measured frequency onto the nearest note code by scanning the note
// table one entry per cycle. Also owns the hz/note/stable result registers so
// that all of them change together with the done pulse.
module note_quantizer
  import tone_meter_pkg::*;
#(
  parameter int LO_HZ = 250,
  parameter int HI_HZ = 1020
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [HZ_W-1:0]   meas_hz,
  output logic [NOTE_W-1:0] note,
  output logic [HZ_W-1:0]   hz,
  output logic              done,
  output logic              stable
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [HZ_W-1:0]   LO_LIM   = HZ_W'(LO_HZ);
  localparam logic [HZ_W-1:0]   HI_LIM   = HZ_W'(HI_HZ);
  localparam logic [NOTE_W-1:0] LAST_IDX = NOTE_W'(NOTE_COUNT);

  logic [1:0]        state;
  logic [HZ_W-1:0]   meas_q;
  logic [HZ_W-1:0]   best_diff;
  logic [NOTE_W-1:0] best_idx;
  logic [NOTE_W-1:0] idx;
  logic [HZ_W-1:0]   diff;
  logic [NOTE_W-1:0] new_note;

  assign diff     = abs_diff(meas_q, NOTE_HZ[idx]);
  assign new_note = ((meas_q < LO_LIM) || (meas_q > HI_LIM)) ? '0 : best_idx;

  // Scan FSM: strict less-than keeps the lower index on a tie; results and the
  // done pulse are registered on leaving DONE so they appear together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      meas_q    <= '0;
      best_diff <= '1;
      best_idx  <= '0;
      idx       <= '0;
      note      <= '0;
      hz        <= '0;
      done      <= 1'b0;
      stable    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            meas_q    <= meas_hz;
            best_diff <= '1;
            best_idx  <= '0;
            idx       <= NOTE_W'(1);
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (diff < best_diff) begin
            best_diff <= diff;
            best_idx  <= idx;
          end
          if (idx == LAST_IDX) begin
            state <= DONE;
          end else begin
            idx <= idx + NOTE_W'(1);
          end
        end
        DONE: begin
          note   <= new_note;
          hz     <= meas_q;
          stable <= (new_note == note) && (new_note != '0);
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tone_meter.sv
// Gated frequency counter for a square-wave tone: counts synchronized rising
// edges over a fixed window, converts the count to Hz and hands it to the note
// quantizer.
module tone_meter
  import tone_meter_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int GATE_SHIFT = 2,
  parameter int LO_HZ      = 250,
  parameter int HI_HZ      = 1020
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tone_in,
  output logic [HZ_W-1:0]   hz,
  output logic [NOTE_W-1:0] note,
  output logic              valid,
  output logic              stable
);

  localparam int GATE_CYCLES = CLK_HZ >> GATE_SHIFT;
  localparam int GW          = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  logic [2:0]      sync_q;
  logic            rise;
  logic [GW-1:0]   gate_cnt;
  logic            wrap;
  logic [9:0]      edge_cnt;
  logic [9:0]      cap_cnt;
  logic            latch_q;
  logic [HZ_W-1:0] meas_hz;

  assign rise    = sync_q[1] & ~sync_q[2];
  assign wrap    = (gate_cnt == GATE_LAST);
  assign meas_hz = {2'b00, cap_cnt} << GATE_SHIFT;

  // Two-flop synchronizer plus a delayed copy for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], tone_in};
  end

  // Free-running gate window counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       gate_cnt <= '0;
    else if (wrap) gate_cnt <= '0;
    else           gate_cnt <= gate_cnt + GW'(1);
  end

  // Saturating edge counter; an edge on the wrap cycle opens the next window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
      cap_cnt  <= '0;
      latch_q  <= 1'b0;
    end else begin
      latch_q <= wrap;
      if (wrap) begin
        cap_cnt  <= edge_cnt;
        edge_cnt <= {9'd0, rise};
      end else if (rise && (edge_cnt != '1)) begin
        edge_cnt <= edge_cnt + 10'd1;
      end
    end
  end

  note_quantizer #(
    .LO_HZ(LO_HZ),
    .HI_HZ(HI_HZ)
  ) u_quant (
    .clk    (clk),
    .rst    (rst),
    .start  (latch_q),
    .meas_hz(meas_hz),
    .note   (note),
    .hz     (hz),
    .done   (valid),
    .stable (stable)
  );

endmodule

// File: doc/tone_meter.md
Name: tone_meter

Overview:
- Measures the frequency of an external square-wave tone (buzzer tap or microphone comparator) with a fixed gate window.
- Quantizes the measured frequency to the nearest note of the 4C..5B table that the music player uses.
- Receiver-side counterpart of the buzzer playback path: playback turns hz into a square wave; this block turns a square wave back into hz and a note code, for score capture and playback self-test.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- GATE_SHIFT, 2, gate window = CLK_HZ >> GATE_SHIFT cycles (0.25 s); hz = edge_count << GATE_SHIFT.
- LO_HZ, 250, measured hz below this decodes as silence (note 0).
- HI_HZ, 1020, measured hz above this decodes as silence (note 0).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tone_in  in  1  asynchronous square-wave input.
- hz  out  12  measured frequency of the last completed window, Hz.
- note  out  5  0 = no voice; 1..24 = 4C,4C#,...,4B,5C,...,5B.
- valid  out  1  one-cycle pulse when hz/note update.
- stable  out  1  high while the last two windows decoded the same nonzero note.

Behaviour:
- Reset (async, active-high): hz=0, note=0, valid=0, stable=0; all counters, synchronizer and FSM cleared. Deassertion starts a fresh window at gate count 0.
- Input path:
  - 2-FF synchronizer on tone_in, then rising-edge detect (existing edge_gen).
  - Edge latency from pin to count is 3 cycles.
- Gate counter:
  - Runs 0..GATE_CYCLES-1 continuously, then wraps.
  - On the wrap cycle, the edge counter value is latched into cap_cnt and the edge counter reloads to 0.
  - If an edge occurs on the wrap cycle, the reload value is 1 instead: the edge counts into the new window and none is lost.
- Edge counter: 10 bits, saturates at 1023 with no wrap. meas_hz = cap_cnt << GATE_SHIFT, truncated to 12 bits.
- Quantizer FSM (states IDLE, SCAN, DONE):
  - IDLE: on latch, load meas_hz, set best_diff=0xFFF, best_idx=0, idx=1 -> SCAN.
  - SCAN: one table entry per cycle. diff = |meas_hz - NOTE_HZ[idx]|. If diff < best_diff (strict, so a tie keeps the lower index), update best_diff and best_idx. After idx=24 -> DONE.
  - DONE: if meas_hz < LO_HZ or meas_hz > HI_HZ, note=0, otherwise note=best_idx. hz=meas_hz. valid=1 for exactly this cycle -> IDLE.
- Timing: latch to valid is 26 cycles, far below any gate window. A new latch can never arrive during SCAN for GATE_CYCLES >= 32, which is a legal-parameter constraint.
- stable: updated in DONE. Set if the new note equals the previous note and the new note is nonzero; otherwise cleared. Holds its value between valid pulses.
- hz and note hold between valid pulses.
- Reset mid-SCAN aborts the scan; no valid pulse is issued.

Decomposition:
- Shared package holds:
  - note frequency constants (_4C.._5B, NO_VOICE), shared with music_player;
  - NOTE_COUNT=24;
  - the NOTE_HZ index table (index 1..24);
  - the note code width.
- One sub-module: note_quantizer, containing the IDLE/SCAN/DONE FSM with inputs meas_hz and start, and outputs note and done.
- Synchronizer, edge detect and gate/edge counters stay in tone_meter.

Test Plan (CLK_HZ=4000, GATE_SHIFT=2 -> 1000-cycle window; the bench forces an exact number of rising edges per window):
- Reset during activity: assert rst asynchronously mid-window -> all outputs 0 immediately; no valid until one full window after release.
- 110 edges/window -> hz=440, note=10 (4A), valid one cycle, 26 cycles after window end.
- 131 edges (524 Hz) then 131 again -> note=13 (5C) both times; stable=0 after the first window, 1 after the second; a following 0-edge window -> note=0, stable=0.
- Out of range: 60 edges (240 Hz) -> hz=240, note=0; 256 edges (1024 Hz) -> note=0; tone held high -> hz=0, note=0.
- Boundary and tie: 65 edges (260 Hz) -> note=1 (4C). Edge landing on the wrap cycle -> counted in the next window; totals across windows are conserved.
- Saturation: more than 1023 edges in a window -> cap_cnt=1023, hz=4092, note=0, no counter wrap.
